// File: rtl/lc4_div_ctrl.sv
// Issue/writeback controller for the combinational LC4 divider: registers operands,
// holds them for LATENCY cycles (multicycle path), then presents DIV/MOD result downstream.
module lc4_div_ctrl #(
   parameter int LATENCY = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        gwe,
   input  logic        i_flush,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic        i_op_mod,
   input  logic [15:0] i_dividend,
   input  logic [15:0] i_divisor,
   input  logic [2:0]  i_rd,
   output logic [15:0] o_div_dividend,
   output logic [15:0] o_div_divisor,
   input  logic [15:0] i_div_quotient,
   input  logic [15:0] i_div_remainder,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [15:0] o_result,
   output logic [2:0]  o_rd,
   output logic        o_div_by_zero,
   output logic        o_busy
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic        r_op_mod;
   logic [2:0]  r_rd;
   logic [15:0] r_dividend;
   logic [15:0] r_divisor;
   logic [15:0] r_result;
   logic [2:0]  r_rd_out;
   logic        r_dbz;
   logic        w_take;

   // Ready depends only on state and downstream ready, never on i_valid.
   assign o_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && i_ready);
   assign w_take  = i_valid & o_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= 4'd0;
         r_op_mod   <= 1'b0;
         r_rd       <= 3'd0;
         r_dividend <= 16'd0;
         r_divisor  <= 16'd0;
         r_result   <= 16'd0;
         r_rd_out   <= 3'd0;
         r_dbz      <= 1'b0;
      end else if (gwe) begin
         if (i_flush) begin
            r_state <= S_IDLE;
         end else if (w_take) begin
            // Covers IDLE accept and the DONE->WAIT overlap with the output transfer.
            r_dividend <= i_dividend;
            r_divisor  <= i_divisor;
            r_op_mod   <= i_op_mod;
            r_rd       <= i_rd;
            r_cnt      <= CNT_INIT;
            r_state    <= S_WAIT;
         end else begin
            case (r_state)
               S_WAIT: begin
                  if (r_cnt == 4'd0) begin
                     r_result <= r_op_mod ? i_div_remainder : i_div_quotient;
                     r_rd_out <= r_rd;
                     r_dbz    <= (r_divisor == 16'd0);
                     r_state  <= S_DONE;
                  end else begin
                     r_cnt <= r_cnt - 4'd1;
                  end
               end
               S_DONE: begin
                  if (i_ready) r_state <= S_IDLE;
               end
               default: ;
            endcase
         end
      end
   end

   assign o_div_dividend = r_dividend;
   assign o_div_divisor  = r_divisor;
   assign o_valid        = (r_state == S_DONE);
   assign o_result       = r_result;
   assign o_rd           = r_rd_out;
   assign o_div_by_zero  = r_dbz;
   assign o_busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_lc4_div_ctrl.sv
// Scoreboard bench for lc4_div_ctrl: behavioural timing model plus expected-result queue,
// directed scenarios followed by randomized handshake/flush/gwe/reset traffic.
module tb_lc4_div_ctrl;

   localparam int LAT = 4;

   logic        clk = 1'b0;
   logic        rst_n, gwe, i_flush, i_valid, i_op_mod, i_ready;
   logic [15:0] i_dividend, i_divisor;
   logic [2:0]  i_rd;
   logic        o_ready, o_valid, o_div_by_zero, o_busy;
   logic [15:0] o_div_dividend, o_div_divisor, o_result;
   logic [2:0]  o_rd;
   logic [15:0] w_q, w_r;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;
   bit en_mon = 0;

   typedef struct {
      logic [15:0] res;
      logic [2:0]  rd;
      logic        dbz;
   } exp_t;
   exp_t sb_q[$];

   int          m_phase;
   int          m_left;
   logic [15:0] m_dvd, m_dvs;

   lc4_div_ctrl #(.LATENCY(LAT)) dut (
      .clk(clk), .rst_n(rst_n), .gwe(gwe), .i_flush(i_flush), .i_valid(i_valid),
      .o_ready(o_ready), .i_op_mod(i_op_mod), .i_dividend(i_dividend), .i_divisor(i_divisor),
      .i_rd(i_rd), .o_div_dividend(o_div_dividend), .o_div_divisor(o_div_divisor),
      .i_div_quotient(w_q), .i_div_remainder(w_r), .o_valid(o_valid), .i_ready(i_ready),
      .o_result(o_result), .o_rd(o_rd), .o_div_by_zero(o_div_by_zero), .o_busy(o_busy)
   );

   // Combinational divider stand-in; 0 results on a zero divisor.
   assign w_q = (o_div_divisor == 16'd0) ? 16'd0 : o_div_dividend / o_div_divisor;
   assign w_r = (o_div_divisor == 16'd0) ? 16'd0 : o_div_dividend % o_div_divisor;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Reference model: phase 0 idle, 1 computing (m_left edges to go), 2 holding result.
   task automatic model_accept();
      exp_t e;
      e.res = (i_divisor == 16'd0) ? 16'd0 :
              (i_op_mod ? i_dividend % i_divisor : i_dividend / i_divisor);
      e.rd  = i_rd;
      e.dbz = (i_divisor == 16'd0);
      sb_q.push_back(e);
      m_dvd   = i_dividend;
      m_dvs   = i_divisor;
      m_left  = LAT;
      m_phase = 1;
   endtask

   initial begin
      m_phase = 0; m_left = 0; m_dvd = 0; m_dvs = 0;
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            m_phase = 0; m_left = 0; m_dvd = 0; m_dvs = 0;
            sb_q.delete();
         end else if (gwe) begin
            if (i_flush) begin
               m_phase = 0;
               sb_q.delete();
            end else if (m_phase == 0) begin
               if (i_valid) model_accept();
            end else if (m_phase == 1) begin
               m_left--;
               if (m_left == 0) m_phase = 2;
            end else if (i_ready) begin
               if (sb_q.size() > 0) void'(sb_q.pop_front());
               if (i_valid) model_accept();
               else m_phase = 0;
            end
         end
      end
   end

   // Monitor: compares handshake/state outputs every cycle and the result whenever valid.
   initial begin
      forever begin
         @(negedge clk);
         if (en_mon) begin
            chk("o_valid", o_valid, m_phase == 2);
            chk("o_ready", o_ready, (m_phase == 0) || (m_phase == 2 && i_ready));
            chk("o_busy", o_busy, m_phase != 0);
            chk("o_div_dividend", o_div_dividend, m_dvd);
            chk("o_div_divisor", o_div_divisor, m_dvs);
            if (o_valid) begin
               chk("sb_nonempty", sb_q.size() > 0, 1);
               if (sb_q.size() > 0) begin
                  chk("o_result", o_result, sb_q[0].res);
                  chk("o_rd", o_rd, sb_q[0].rd);
                  chk("o_div_by_zero", o_div_by_zero, sb_q[0].dbz);
               end
            end
         end
      end
   end

   task automatic issue(input logic m, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] rd, output int acc);
      bit rdy;
      acc = -1;
      i_valid = 1; i_op_mod = m; i_dividend = a; i_divisor = b; i_rd = rd;
      for (int k = 0; k < 50; k++) begin
         rdy = o_ready && gwe && !i_flush && rst_n;
         step(1);
         if (rdy) begin
            acc = cyc;
            i_valid = 0;
            return;
         end
      end
      i_valid = 0;
      n_chk++; n_err++;
      $display("FAIL issue_timeout: got no accept, expected accept within 50 cycles");
   endtask

   task automatic wait_valid(output int k);
      k = 0;
      while (!o_valid && k < 40) begin
         step(1);
         k++;
      end
   endtask

   task automatic wait_idle();
      int k = 0;
      while (o_busy && k < 40) begin
         step(1);
         k++;
      end
      if (o_busy) begin
         n_chk++; n_err++;
         $display("FAIL idle_timeout: got busy=1, expected busy=0 within 40 cycles");
      end
   endtask

   task automatic chk_reset_vals();
      chk("rst_valid", o_valid, 0);
      chk("rst_ready", o_ready, 1);
      chk("rst_busy", o_busy, 0);
      chk("rst_result", o_result, 0);
      chk("rst_rd", o_rd, 0);
      chk("rst_dbz", o_div_by_zero, 0);
      chk("rst_dividend", o_div_dividend, 0);
      chk("rst_divisor", o_div_divisor, 0);
   endtask

   initial begin
      int a1, a2, k;
      logic [15:0] held;
      rst_n = 0; gwe = 1; i_flush = 0; i_valid = 0; i_op_mod = 0; i_ready = 1;
      i_dividend = 0; i_divisor = 0; i_rd = 0;
      step(2);
      chk_reset_vals();
      rst_n = 1;
      en_mon = 1;
      step(1);

      // DIV 100/7, latency and tag
      issue(0, 16'd100, 16'd7, 3'd5, a1);
      wait_valid(k);
      chk("div_latency", k, LAT);
      chk("div_result", o_result, 14);
      chk("div_rd", o_rd, 5);
      chk("div_dbz", o_div_by_zero, 0);
      step(1);
      chk("div_then_idle", o_busy, 0);

      // Back-to-back MOD ops, second accepted on the first transfer edge
      issue(1, 16'd100, 16'd7, 3'd1, a1);
      issue(1, 16'hFFFF, 16'h0010, 3'd2, a2);
      chk("b2b_spacing", a2 - a1, LAT + 1);
      wait_valid(k);
      chk("b2b_result2", o_result, 15);
      wait_idle();

      // Divide by zero
      issue(0, 16'd1234, 16'd0, 3'd3, a1);
      wait_valid(k);
      chk("dbz_div_result", o_result, 0);
      chk("dbz_div_flag", o_div_by_zero, 1);
      issue(1, 16'd1234, 16'd0, 3'd4, a1);
      wait_valid(k);
      chk("dbz_mod_result", o_result, 0);
      chk("dbz_mod_flag", o_div_by_zero, 1);
      wait_idle();

      // Backpressure for 3 cycles, transfer on the 4th
      i_ready = 0;
      issue(0, 16'd5000, 16'd9, 3'd6, a1);
      wait_valid(k);
      held = o_result;
      chk("bp_first_result", held, 555);
      for (int c = 0; c < 3; c++) begin
         step(1);
         chk("bp_valid_held", o_valid, 1);
         chk("bp_result_held", o_result, held);
         chk("bp_rd_held", o_rd, 6);
         chk("bp_ready_low", o_ready, 0);
      end
      i_ready = 1;
      step(1);
      chk("bp_transferred", o_valid, 0);

      // Flush two cycles into WAIT with a competing i_valid
      issue(0, 16'd300, 16'd3, 3'd7, a1);
      step(2);
      i_flush = 1; i_valid = 1; i_dividend = 16'd77; i_divisor = 16'd11; i_rd = 3'd2;
      step(1);
      i_flush = 0; i_valid = 0;
      chk("flush_busy", o_busy, 0);
      chk("flush_ready", o_ready, 1);
      step(6);
      chk("flush_no_valid", o_valid, 0);
      issue(1, 16'd77, 16'd11, 3'd2, a1);
      wait_valid(k);
      chk("post_flush_latency", k, LAT);
      chk("post_flush_result", o_result, 0);
      wait_idle();

      // gwe low for 2 cycles in WAIT, then reset while holding in DONE
      i_ready = 0;
      issue(0, 16'd40000, 16'd3, 3'd1, a1);
      step(1);
      gwe = 0;
      step(2);
      gwe = 1;
      wait_valid(k);
      chk("gwe_latency", k + 3, LAT + 2);
      chk("gwe_result", o_result, 13333);
      rst_n = 0;
      step(1);
      chk_reset_vals();
      rst_n = 1; i_ready = 1;
      step(1);

      // Randomized traffic
      for (int c = 0; c < 600; c++) begin
         gwe        = ($urandom_range(0, 9) != 0);
         i_flush    = ($urandom_range(0, 24) == 0);
         i_valid    = ($urandom_range(0, 2) != 0);
         i_ready    = ($urandom_range(0, 3) != 0);
         rst_n      = ($urandom_range(0, 149) != 0);
         i_op_mod   = 1'($urandom_range(0, 1));
         i_dividend = 16'($urandom);
         i_divisor  = ($urandom_range(0, 7) == 0) ? 16'd0 :
                      ($urandom_range(0, 1) ? 16'($urandom_range(1, 300)) : 16'($urandom));
         i_rd       = 3'($urandom_range(0, 7));
         step(1);
      end
      rst_n = 1; gwe = 1; i_flush = 0; i_valid = 0; i_ready = 1;
      wait_idle();
      step(2);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before 200us");
      $fatal(1, "watchdog expired");
   end

endmodule
